seg_addr_gen: RTL and testbench
===============================

// Module: seg_addr_gen
// PURPOSE
//  Read-side companion of the segment register file (CS/DS/SS/ES). Accepts a logical access
//  (segment + 16-bit offset, byte/word) from the execution unit and selects and reads the segment.
//  Forms the 20-bit physical address (seg<<4)+offset and sequences one or two bus cycles.
//  Misaligned words take two cycles. Sits between the execution unit and the bus interface.
// PARAMETERS
//  ADDR_W     20  physical address width; sum is taken mod 2^ADDR_W
//  SEG_SHIFT  4   left shift applied to the segment value
//  SEG_LAT    1   cycles from a stable seg_sel (write_en low) to a valid seg_data
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       reset, asynchronous, active-high
//  req_valid     in   1       logical access request
//  req_ready     out  1       block can accept a request (IDLE only)
//  req_seg       in   2       default segment: 0 CS, 1 DS, 2 SS, 3 ES
//  req_ovr       in   1       segment override present
//  req_ovr_seg   in   2       override segment (wins over req_seg when req_ovr=1)
//  req_offset    in   16      effective offset
//  req_word      in   1       1 = word access, 0 = byte access
//  seg_sel       out  2       register select driven to the segment file
//  seg_rd        out  1       read in progress; segment file write_en must be low
//  seg_wr_active in   1       segment file is being written this cycle
//  seg_data      in   16      registered segment value from the segment file
//  bus_valid     out  1       physical address valid
//  bus_ready     in   1       bus accepts the current cycle
//  bus_addr      out  ADDR_W  physical address
//  bus_bhe_n     out  1       byte-high enable, active low
//  bus_last      out  1       final bus cycle of the access
//  busy          out  1       state != IDLE
// BEHAVIOUR
//  Reset values:
//   - state IDLE; req_ready=1; all other outputs 0, except bus_bhe_n=1.
//   - Latched request and segment registers cleared.
//  FSM states: IDLE, SEG_RD, SEG_CAP, BUS0, BUS1.
//  IDLE:
//   - On req_valid&&req_ready, latch sel=(req_ovr?req_ovr_seg:req_seg), offset and word.
//   - Go to SEG_RD.
//  SEG_RD:
//   - seg_sel=sel and seg_rd=1. Hold for SEG_LAT cycles, counted by a down-counter.
//   - Any cycle with seg_wr_active=1 reloads the counter (retry), so stale data is never captured.
//   - Counter expired and no write -> SEG_CAP.
//  SEG_CAP:
//   - Capture seg_q=seg_data.
//   - Compute a0=(seg_q<<SEG_SHIFT)+offset mod 2^ADDR_W.
//   - Compute a1=(seg_q<<SEG_SHIFT)+((offset+1) mod 2^16) mod 2^ADDR_W. The offset wraps inside
//     the 64 KiB segment; the carry never propagates into the segment.
//   - Go to BUS0.
//  BUS0:
//   - bus_valid=1 and bus_addr=a0. Hold addr/bhe/last stable until bus_ready.
//   - byte, even -> bhe_n=1, last=1
//   - byte, odd -> bhe_n=0, last=1
//   - word, even -> bhe_n=0, last=1 (single cycle)
//   - word, odd -> bhe_n=0, last=0; on ready go to BUS1
//   - last=1 and ready -> IDLE.
//  BUS1:
//   - bus_valid=1, bus_addr=a1, bhe_n=1, last=1.
//   - On ready -> IDLE.
//  Timing and handshake:
//   - Minimum latency from accept to first bus_valid: SEG_LAT+2 cycles.
//   - A new request is accepted no earlier than the cycle after the final bus handshake (no overlap).
//   - bus_valid is never dropped before bus_ready.
//   - Request inputs are ignored outside IDLE.
//  Reset asserted mid-access: immediate return to reset values; the partial bus sequence is abandoned.
// STRUCTURE
//  Shared package seg_pkg:
//   - segment encodings SEG_CS=2'd0, SEG_DS=2'd1, SEG_SS=2'd2, SEG_ES=2'd3
//   - FSM state typedef
//   - ADDR_W default
//  The segment file and all producers use seg_pkg encodings.
//  One natural sub-module: seg_phys_add, a combinational (seg<<SHIFT)+offset adder, instantiated
//  twice (a0, a1). FSM, latency counter and registers stay in the top.
// TESTING
//  1. DS=16'h1234, offset 16'h0010, byte, bus_ready=1
//     -> one cycle: addr 20'h12350, bhe_n=1, last=1; seg_sel=1 during SEG_RD.
//  2. CS=16'hF000, offset 16'h0003, word
//     -> 20'hF0003 bhe_n=0 last=0, then 20'hF0004 bhe_n=1 last=1.
//  3. ES=16'hFFFF, offset 16'hFFFF, word
//     -> a0=20'h0FFEF (20-bit wrap); a1=20'hFFFF0 (offset wrap to 0000).
//  4. req_seg=SS, req_ovr=1, req_ovr_seg=ES -> seg_sel=3.
//     Also: seg_wr_active pulses in SEG_RD -> SEG_RD extends, and the captured value is post-write.
//  5. Hold bus_ready=0 for 5 cycles in BUS0 -> addr/bhe/last stable and req_ready=0.
//     Then assert ready -> IDLE, req_ready=1 the next cycle.
//  6. Assert rst during BUS1 -> bus_valid=0, bhe_n=1, req_ready=1 immediately.
//     Then a fresh byte request completes normally.

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared segment encodings, FSM state type and address defaults
package seg_pkg;

  localparam int ADDR_W_DEF    = 20;
  localparam int SEG_SHIFT_DEF = 4;
  localparam int SEG_LAT_DEF   = 1;

  localparam logic [1:0] SEG_CS = 2'd0;
  localparam logic [1:0] SEG_DS = 2'd1;
  localparam logic [1:0] SEG_SS = 2'd2;
  localparam logic [1:0] SEG_ES = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEG_RD,
    ST_SEG_CAP,
    ST_BUS0,
    ST_BUS1
  } state_t;

  // An override prefix always wins over the instruction's default segment.
  function automatic logic [1:0] eff_seg(input logic ovr, input logic [1:0] ovr_seg,
                                         input logic [1:0] def_seg);
    return ovr ? ovr_seg : def_seg;
  endfunction

endpackage

// File: rtl/seg_addr_gen_if.sv
// rtl/seg_addr_gen_if.sv - request, segment-file and bus signals of the address generator
interface seg_addr_gen_if #(
  parameter int ADDR_W = seg_pkg::ADDR_W_DEF
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_seg;
  logic              req_ovr;
  logic [1:0]        req_ovr_seg;
  logic [15:0]       req_offset;
  logic              req_word;
  logic [1:0]        seg_sel;
  logic              seg_rd;
  logic              seg_wr_active;
  logic [15:0]       seg_data;
  logic              bus_valid;
  logic              bus_ready;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_bhe_n;
  logic              bus_last;
  logic              busy;

  modport slave (
    input  req_valid, req_seg, req_ovr, req_ovr_seg, req_offset, req_word,
    input  seg_wr_active, seg_data, bus_ready,
    output req_ready, seg_sel, seg_rd, bus_valid, bus_addr, bus_bhe_n, bus_last, busy
  );

  modport master (
    output req_valid, req_seg, req_ovr, req_ovr_seg, req_offset, req_word,
    output seg_wr_active, seg_data, bus_ready,
    input  req_ready, seg_sel, seg_rd, bus_valid, bus_addr, bus_bhe_n, bus_last, busy
  );
endinterface

// File: rtl/seg_phys_add.sv
// rtl/seg_phys_add.sv - combinational (seg << SEG_SHIFT) + offset, truncated to ADDR_W
module seg_phys_add
  import seg_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int SEG_SHIFT = SEG_SHIFT_DEF
) (
  input  logic [15:0]       seg,
  input  logic [15:0]       offset,
  output logic [ADDR_W-1:0] addr
);

  assign addr = (ADDR_W'(seg) << SEG_SHIFT) + ADDR_W'(offset);

endmodule

// File: rtl/seg_addr_gen.sv
// rtl/seg_addr_gen.sv - reads the selected segment and sequences one or two physical bus cycles
module seg_addr_gen
  import seg_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int SEG_SHIFT = SEG_SHIFT_DEF,
  parameter int SEG_LAT   = SEG_LAT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  seg_addr_gen_if.slave io
);

  localparam int               CNT_W    = (SEG_LAT > 1) ? $clog2(SEG_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SEG_LAT - 1);

  state_t            state, state_nx;
  logic [1:0]        sel_q;
  logic [15:0]       off_q;
  logic [15:0]       seg_q;
  logic              word_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [15:0]       off_p1;
  logic [ADDR_W-1:0] a0, a1;
  logic              split;

  logic              req_ready_c, seg_rd_c, bus_valid_c, bhe_n_c, last_c, busy_c;
  logic [1:0]        seg_sel_c;
  logic [ADDR_W-1:0] addr_c;

  // Second beat wraps inside the 64 KiB segment, never carrying into it.
  assign off_p1 = off_q + 16'd1;
  assign split  = word_q & off_q[0];

  seg_phys_add #(.ADDR_W(ADDR_W), .SEG_SHIFT(SEG_SHIFT)) u_add0 (
    .seg(seg_q), .offset(off_q), .addr(a0)
  );

  seg_phys_add #(.ADDR_W(ADDR_W), .SEG_SHIFT(SEG_SHIFT)) u_add1 (
    .seg(seg_q), .offset(off_p1), .addr(a1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      sel_q  <= 2'd0;
      off_q  <= 16'd0;
      word_q <= 1'b0;
      seg_q  <= 16'd0;
      cnt_q  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (io.req_valid) begin
            sel_q  <= eff_seg(io.req_ovr, io.req_ovr_seg, io.req_seg);
            off_q  <= io.req_offset;
            word_q <= io.req_word;
            cnt_q  <= CNT_LOAD;
          end
        end
        ST_SEG_RD: begin
          // A concurrent write may make the in-flight read stale: restart the wait.
          if (io.seg_wr_active)   cnt_q <= CNT_LOAD;
          else if (cnt_q != '0)   cnt_q <= cnt_q - CNT_W'(1);
        end
        ST_SEG_CAP: seg_q <= io.seg_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx    = state;
    req_ready_c = 1'b0;
    seg_sel_c   = 2'd0;
    seg_rd_c    = 1'b0;
    bus_valid_c = 1'b0;
    addr_c      = '0;
    bhe_n_c     = 1'b1;
    last_c      = 1'b0;
    busy_c      = 1'b1;
    case (state)
      ST_IDLE: begin
        req_ready_c = 1'b1;
        busy_c      = 1'b0;
        if (io.req_valid) state_nx = ST_SEG_RD;
      end
      ST_SEG_RD: begin
        seg_sel_c = sel_q;
        seg_rd_c  = 1'b1;
        if (!io.seg_wr_active && cnt_q == '0) state_nx = ST_SEG_CAP;
      end
      ST_SEG_CAP: state_nx = ST_BUS0;
      ST_BUS0: begin
        bus_valid_c = 1'b1;
        addr_c      = a0;
        bhe_n_c     = ~word_q & ~off_q[0];
        last_c      = ~split;
        if (io.bus_ready) state_nx = split ? ST_BUS1 : ST_IDLE;
      end
      ST_BUS1: begin
        bus_valid_c = 1'b1;
        addr_c      = a1;
        bhe_n_c     = 1'b1;
        last_c      = 1'b1;
        if (io.bus_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign io.req_ready = req_ready_c;
  assign io.seg_sel   = seg_sel_c;
  assign io.seg_rd    = seg_rd_c;
  assign io.bus_valid = bus_valid_c;
  assign io.bus_addr  = addr_c;
  assign io.bus_bhe_n = bhe_n_c;
  assign io.bus_last  = last_c;
  assign io.busy      = busy_c;

endmodule

// File: tb/tb_seg_addr_gen.sv
// tb/tb_seg_addr_gen.sv - randomized bench for seg_addr_gen against an arithmetic reference model
module tb_seg_addr_gen;
  import seg_pkg::*;

  typedef struct packed {
    logic [19:0] addr;
    logic        bhe_n;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_addr_gen_if #(.ADDR_W(20)) sif ();

  seg_addr_gen #(.ADDR_W(20), .SEG_SHIFT(4), .SEG_LAT(1)) dut (
    .clk(clk),
    .rst(rst),
    .io (sif.slave)
  );

  // Segment register file: registered read, write visible to reads one cycle later.
  logic [15:0] segs [4];
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [15:0] wr_val;

  always @(posedge clk) begin
    if (wr_en) segs[wr_sel] <= wr_val;
    sif.seg_data <= segs[sif.seg_sel];
  end
  assign sif.seg_wr_active = wr_en;

  int unsigned model_seg [4];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int unsigned phys(input int unsigned seg, input int unsigned off);
    return (seg * 16 + off) % 32'h0010_0000;
  endfunction

  task automatic set_seg(input int s, input int unsigned v);
    @(negedge clk);
    wr_en  = 1'b1;
    wr_sel = 2'(s);
    wr_val = 16'(v);
    model_seg[s] = v;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // rmode: 0 always ready, 1 random ready, 2 stall the first five valid cycles
  task automatic access(input int dseg, input bit ovr, input int oseg, input int unsigned off,
                        input bit word, input bit pulse, input int rmode, input bit rst_in_bus1);
    int          sel;
    int unsigned sv, newv;
    beat_t       q[$];
    beat_t       b;
    int          rd_cycles, lat, hold;
    bit          done, two_beat, rdy;

    sel       = ovr ? oseg : dseg;
    newv      = $urandom_range(0, 65535);
    sv        = pulse ? newv : model_seg[sel];
    rd_cycles = 0;
    lat       = -1;
    hold      = 0;
    done      = 1'b0;
    two_beat  = word && (off % 2 == 1);

    if (two_beat) begin
      b.addr = 20'(phys(sv, off));             b.bhe_n = 1'b0; b.last = 1'b0; q.push_back(b);
      b.addr = 20'(phys(sv, (off + 1) % 65536)); b.bhe_n = 1'b1; b.last = 1'b1; q.push_back(b);
    end else begin
      b.addr  = 20'(phys(sv, off));
      b.bhe_n = !word && (off % 2 == 0);
      b.last  = 1'b1;
      q.push_back(b);
    end

    @(negedge clk);
    sif.req_valid   = 1'b1;
    sif.req_seg     = 2'(dseg);
    sif.req_ovr     = ovr;
    sif.req_ovr_seg = 2'(oseg);
    sif.req_offset  = 16'(off);
    sif.req_word    = word;
    check("req_ready_idle", 32'(sif.req_ready), 32'd1);

    for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
      @(negedge clk);
      sif.req_valid   = 1'($urandom % 2);
      sif.req_seg     = 2'($urandom);
      sif.req_ovr     = 1'($urandom);
      sif.req_ovr_seg = 2'($urandom);
      sif.req_offset  = 16'($urandom);
      sif.req_word    = 1'($urandom);
      wr_en           = 1'b0;
      sif.bus_ready   = 1'b0;
      check("req_ready_busy", 32'(sif.req_ready), 32'd0);
      if (sif.seg_rd) begin
        rd_cycles++;
        check("seg_sel", 32'(sif.seg_sel), 32'(sel));
        if (pulse && rd_cycles == 1) begin
          wr_en  = 1'b1;
          wr_sel = 2'(sel);
          wr_val = 16'(newv);
          model_seg[sel] = newv;
        end
      end
      if (sif.bus_valid) begin
        if (lat < 0) begin
          lat = cyc;
          check("latency", 32'(cyc), 32'(3 + int'(pulse)));
          check("seg_rd_cycles", 32'(rd_cycles), 32'(1 + int'(pulse)));
        end
        if (q.size() == 0) begin
          check("extra_beat", 32'(sif.bus_valid), 32'd0);
          done = 1'b1;
        end else begin
          check("bus_addr", 32'(sif.bus_addr), 32'(q[0].addr));
          check("bus_bhe_n", 32'(sif.bus_bhe_n), 32'(q[0].bhe_n));
          check("bus_last", 32'(sif.bus_last), 32'(q[0].last));
          if (rst_in_bus1 && two_beat && q.size() == 1) begin
            rst = 1'b1;
            #1;
            check("rst_bus_valid", 32'(sif.bus_valid), 32'd0);
            check("rst_bhe_n", 32'(sif.bus_bhe_n), 32'd1);
            check("rst_req_ready", 32'(sif.req_ready), 32'd1);
            check("rst_busy", 32'(sif.busy), 32'd0);
            check("rst_last", 32'(sif.bus_last), 32'd0);
            @(negedge clk);
            sif.req_valid = 1'b0;
            rst = 1'b0;
            done = 1'b1;
          end else begin
            case (rmode)
              0:       rdy = 1'b1;
              1:       rdy = 1'($urandom % 2);
              default: rdy = (hold >= 5);
            endcase
            hold++;
            sif.bus_ready = rdy;
            if (rdy) begin
              void'(q.pop_front());
              if (q.size() == 0) done = 1'b1;
            end
          end
        end
      end
    end
    if (!done) check("access_timeout", 32'(done), 32'd1);

    if (!rst_in_bus1) begin
      @(negedge clk);
      sif.req_valid = 1'b0;
      sif.bus_ready = 1'b0;
      wr_en         = 1'b0;
      check("post_req_ready", 32'(sif.req_ready), 32'd1);
      check("post_bus_valid", 32'(sif.bus_valid), 32'd0);
      check("post_busy", 32'(sif.busy), 32'd0);
    end
  endtask

  initial begin
    sif.req_valid   = 1'b0;
    sif.req_seg     = 2'd0;
    sif.req_ovr     = 1'b0;
    sif.req_ovr_seg = 2'd0;
    sif.req_offset  = 16'd0;
    sif.req_word    = 1'b0;
    sif.bus_ready   = 1'b0;
    wr_en           = 1'b0;
    wr_sel          = 2'd0;
    wr_val          = 16'd0;
    #1;
    check("rst_req_ready0", 32'(sif.req_ready), 32'd1);
    check("rst_bus_valid0", 32'(sif.bus_valid), 32'd0);
    check("rst_bhe_n0", 32'(sif.bus_bhe_n), 32'd1);
    check("rst_bus_last0", 32'(sif.bus_last), 32'd0);
    check("rst_bus_addr0", 32'(sif.bus_addr), 32'd0);
    check("rst_seg_rd0", 32'(sif.seg_rd), 32'd0);
    check("rst_seg_sel0", 32'(sif.seg_sel), 32'd0);
    check("rst_busy0", 32'(sif.busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    set_seg(SEG_CS, 32'hF000);
    set_seg(SEG_DS, 32'h1234);
    set_seg(SEG_SS, 32'h5555);
    set_seg(SEG_ES, 32'hFFFF);

    access(SEG_DS, 1'b0, 0,      32'h0010, 1'b0, 1'b0, 0, 1'b0);
    access(SEG_CS, 1'b0, 0,      32'h0003, 1'b1, 1'b0, 0, 1'b0);
    access(SEG_ES, 1'b0, 0,      32'hFFFF, 1'b1, 1'b0, 0, 1'b0);
    access(SEG_SS, 1'b1, SEG_ES, 32'h0100, 1'b1, 1'b1, 0, 1'b0);
    access(SEG_DS, 1'b0, 0,      32'h0021, 1'b0, 1'b0, 2, 1'b0);
    access(SEG_CS, 1'b0, 0,      32'h0101, 1'b1, 1'b0, 0, 1'b1);
    access(SEG_DS, 1'b0, 0,      32'h0042, 1'b0, 1'b0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom % 4 == 0) set_seg(int'($urandom % 4), $urandom_range(0, 65535));
      access(int'($urandom % 4), 1'($urandom), int'($urandom % 4), $urandom_range(0, 65535),
             1'($urandom), 1'($urandom), int'($urandom % 3), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
